// File: rtl/mips_cpu_pkg.sv
// Shared types for the CPU writeback path: load-type and writeback-state encodings.
// Pure declarations, no logic or latency.
// No flow control here; consumers apply their own handshakes.
package mips_cpu_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 32;

  // Register $0 is hardwired to zero: writes to it are suppressed.
  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [2:0] {
    LT_LW  = 3'd0,
    LT_LB  = 3'd1,
    LT_LBU = 3'd2,
    LT_LH  = 3'd3,
    LT_LHU = 3'd4,
    LT_LWL = 3'd5,
    LT_LWR = 3'd6
  } load_type_t;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_MEM = 2'd1,
    ST_WRITE    = 2'd2
  } wb_state_t;

endpackage

// File: rtl/mips_cpu_writeback_ctrl_if.sv
// Bundles the request, memory-return, register-file and hazard signals of the writeback controller.
// No latency of its own.
// req_valid/req_ready handshake for requests; mem_readvalid is a one-cycle strobe with no backpressure.
interface mips_cpu_writeback_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_load;
  logic [ADDR_W-1:0] req_dest;
  logic [DATA_W-1:0] req_alu_data;
  logic [2:0]        req_load_type;
  logic [1:0]        req_byte_off;
  logic [DATA_W-1:0] mem_readdata;
  logic              mem_readvalid;
  logic [ADDR_W-1:0] rf_read_addr;
  logic [DATA_W-1:0] rf_read_data;
  logic [ADDR_W-1:0] regfile_write_addr;
  logic              regfile_write_enable;
  logic [DATA_W-1:0] regfile_write_data;
  logic              pending_valid;
  logic [ADDR_W-1:0] pending_dest;

  // Controller side.
  modport master (
    input  req_valid, req_is_load, req_dest, req_alu_data, req_load_type, req_byte_off,
    input  mem_readdata, mem_readvalid, rf_read_data,
    output req_ready, rf_read_addr,
    output regfile_write_addr, regfile_write_enable, regfile_write_data,
    output pending_valid, pending_dest
  );

  // Execute stage / memory / register file side.
  modport slave (
    output req_valid, req_is_load, req_dest, req_alu_data, req_load_type, req_byte_off,
    output mem_readdata, mem_readvalid, rf_read_data,
    input  req_ready, rf_read_addr,
    input  regfile_write_addr, regfile_write_enable, regfile_write_data,
    input  pending_valid, pending_dest
  );
endinterface

// File: rtl/mips_cpu_load_align.sv
// Byte-lane select, sign/zero extension and LWL/LWR merge of load data.
// Purely combinational, zero cycles.
// No flow control.
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  logic [2:0]  load_type_i,
  input  logic [1:0]  byte_off_i,
  input  logic [31:0] mem_data_i,
  input  logic [31:0] old_data_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword (little-endian lanes).
  always_comb begin
    byte_sel = mem_data_i[7:0];
    case (byte_off_i)
      2'd0: byte_sel = mem_data_i[7:0];
      2'd1: byte_sel = mem_data_i[15:8];
      2'd2: byte_sel = mem_data_i[23:16];
      2'd3: byte_sel = mem_data_i[31:24];
      default: byte_sel = mem_data_i[7:0];
    endcase
    half_sel = byte_off_i[1] ? mem_data_i[31:16] : mem_data_i[15:0];
  end

  // Extend or merge per load type; the unused encoding 7 behaves as LW.
  always_comb begin
    data_o = mem_data_i;
    case (load_type_i)
      LT_LB:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU: data_o = {24'd0, byte_sel};
      LT_LH:  data_o = {{16{half_sel[15]}}, half_sel};
      LT_LHU: data_o = {16'd0, half_sel};
      LT_LWL: begin
        case (byte_off_i)
          2'd0: data_o = {mem_data_i[7:0],  old_data_i[23:0]};
          2'd1: data_o = {mem_data_i[15:0], old_data_i[15:0]};
          2'd2: data_o = {mem_data_i[23:0], old_data_i[7:0]};
          default: data_o = mem_data_i;
        endcase
      end
      LT_LWR: begin
        case (byte_off_i)
          2'd1: data_o = {old_data_i[31:24], mem_data_i[31:8]};
          2'd2: data_o = {old_data_i[31:16], mem_data_i[31:16]};
          2'd3: data_o = {old_data_i[31:8],  mem_data_i[31:24]};
          default: data_o = mem_data_i;
        endcase
      end
      default: data_o = mem_data_i;
    endcase
  end

endmodule

// File: rtl/mips_cpu_writeback_ctrl.sv
// Writeback controller: accepts ALU/load requests and issues one register-file write per request.
// ALU: strobe one cycle after accept; load: strobe one cycle after mem_readvalid.
// req_ready low while waiting on memory; clk_enable low freezes everything and masks the strobe.
module mips_cpu_writeback_ctrl
  import mips_cpu_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clk_enable,
  mips_cpu_writeback_ctrl_if.master  bus
);

  wb_state_t         state_q,   state_d;
  logic [ADDR_W-1:0] dest_q,    dest_d;
  logic              is_load_q, is_load_d;
  logic [2:0]        type_q,    type_d;
  logic [1:0]        off_q,     off_d;
  logic [DATA_W-1:0] alu_q,     alu_d;
  logic [DATA_W-1:0] mem_q,     mem_d;
  logic [DATA_W-1:0] old_q,     old_d;

  logic              ready_w;
  logic              accept_w;
  logic [31:0]       load_data_w;
  logic [DATA_W-1:0] wb_data_w;

  assign ready_w   = !reset && (state_q != ST_WAIT_MEM);
  assign accept_w  = clk_enable && bus.req_valid && ready_w;

  mips_cpu_load_align u_align (
    .load_type_i (type_q),
    .byte_off_i  (off_q),
    .mem_data_i  (mem_q),
    .old_data_i  (old_q),
    .data_o      (load_data_w)
  );

  assign wb_data_w = is_load_q ? load_data_w : alu_q;

  // State and captured request; reset wins over the stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      dest_q    <= '0;
      is_load_q <= 1'b0;
      type_q    <= 3'd0;
      off_q     <= 2'd0;
      alu_q     <= '0;
      mem_q     <= '0;
      old_q     <= '0;
    end else if (clk_enable) begin
      state_q   <= state_d;
      dest_q    <= dest_d;
      is_load_q <= is_load_d;
      type_q    <= type_d;
      off_q     <= off_d;
      alu_q     <= alu_d;
      mem_q     <= mem_d;
      old_q     <= old_d;
    end
  end

  // Next state: capture on accept (IDLE or back-to-back from WRITE), capture memory data on readvalid.
  always_comb begin
    state_d   = state_q;
    dest_d    = dest_q;
    is_load_d = is_load_q;
    type_d    = type_q;
    off_d     = off_q;
    alu_d     = alu_q;
    mem_d     = mem_q;
    old_d     = old_q;
    case (state_q)
      ST_WAIT_MEM: begin
        if (bus.mem_readvalid) begin
          mem_d   = bus.mem_readdata;
          old_d   = bus.rf_read_data;
          state_d = ST_WRITE;
        end
      end
      ST_IDLE, ST_WRITE: begin
        if (accept_w) begin
          dest_d    = bus.req_dest;
          is_load_d = bus.req_is_load;
          type_d    = bus.req_load_type;
          off_d     = bus.req_byte_off;
          alu_d     = bus.req_alu_data;
          state_d   = bus.req_is_load ? ST_WAIT_MEM : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: zero under reset; the in-flight destination takes precedence on the pending bus.
  always_comb begin
    bus.req_ready            = 1'b0;
    bus.rf_read_addr         = '0;
    bus.regfile_write_addr   = '0;
    bus.regfile_write_enable = 1'b0;
    bus.regfile_write_data   = '0;
    bus.pending_valid        = 1'b0;
    bus.pending_dest         = '0;
    if (!reset) begin
      bus.req_ready = ready_w;
      if (state_q == ST_WAIT_MEM) begin
        bus.rf_read_addr = dest_q;
      end
      if (state_q == ST_WRITE && dest_q != REG_ZERO) begin
        bus.regfile_write_enable = clk_enable;
        bus.regfile_write_addr   = dest_q;
        bus.regfile_write_data   = wb_data_w;
      end
      if (state_q != ST_IDLE && dest_q != REG_ZERO) begin
        bus.pending_valid = 1'b1;
        bus.pending_dest  = dest_q;
      end else if (accept_w && bus.req_dest != REG_ZERO) begin
        bus.pending_valid = 1'b1;
        bus.pending_dest  = bus.req_dest;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_writeback_ctrl.sv
// Self-checking bench for the writeback controller: directed scenarios plus random transactions.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
// Expected write data comes from the load formulas evaluated with plain shifts and masks.
module tb_mips_cpu_writeback_ctrl;

  logic clk;
  logic reset;
  logic clk_enable;
  int   checks;
  int   errors;

  mips_cpu_writeback_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  mips_cpu_writeback_ctrl #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid     = 1'b0;
    bus.req_is_load   = 1'b0;
    bus.req_dest      = 5'd0;
    bus.req_alu_data  = 32'd0;
    bus.req_load_type = 3'd0;
    bus.req_byte_off  = 2'd0;
    bus.mem_readdata  = 32'd0;
    bus.mem_readvalid = 1'b0;
    bus.rf_read_data  = 32'd0;
  endtask

  // Reference load result straight from the architectural formulas.
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input int k,
                                           input logic [31:0] m, input logic [31:0] old);
    logic [63:0] mm;
    logic [63:0] oo;
    logic [31:0] b;
    logic [31:0] h;
    int          sh;
    mm = {32'd0, m};
    oo = {32'd0, old};
    b  = (m >> (8 * k)) & 32'hFF;
    h  = (m >> (16 * (k / 2))) & 32'hFFFF;
    case (lt)
      3'd1: ref_load = (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
      3'd2: ref_load = b;
      3'd3: ref_load = (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
      3'd4: ref_load = h;
      3'd5: begin
        sh = 8 * (3 - k);
        ref_load = 32'((mm << sh) | (oo & ((64'd1 << sh) - 64'd1)));
      end
      3'd6: ref_load = 32'((mm >> (8 * k)) | (oo & ~(64'hFFFFFFFF >> (8 * k))));
      default: ref_load = m;
    endcase
  endfunction

  // One complete request: accept, optional memory wait, write cycle, return to idle.
  task automatic run_txn(input bit ld, input logic [2:0] lt, input logic [4:0] d,
                         input logic [31:0] alu, input logic [1:0] k,
                         input logic [31:0] m, input logic [31:0] old, input int wait_cycles);
    logic [31:0] exp;
    logic        wr;
    exp = ld ? ref_load(lt, int'(k), m, old) : alu;
    wr  = (d != 5'd0);
    bus.req_valid     = 1'b1;
    bus.req_is_load   = ld;
    bus.req_dest      = d;
    bus.req_alu_data  = alu;
    bus.req_load_type = lt;
    bus.req_byte_off  = k;
    #1;
    chk("accept_ready", bus.req_ready, 1);
    chk("accept_pending", bus.pending_valid, wr);
    if (wr) chk("accept_pdest", bus.pending_dest, d);
    chk("accept_no_we", bus.regfile_write_enable, 0);
    next();
    bus.req_valid     = 1'b0;
    bus.req_dest      = 5'($urandom);
    bus.req_alu_data  = $urandom;
    bus.req_load_type = 3'($urandom);
    bus.req_byte_off  = 2'($urandom);
    if (ld) begin
      for (int i = 0; i < wait_cycles; i++) begin
        bus.rf_read_data = $urandom;
        #1;
        chk("wait_no_we", bus.regfile_write_enable, 0);
        chk("wait_rdaddr", bus.rf_read_addr, d);
        chk("wait_ready", bus.req_ready, 0);
        chk("wait_pending", bus.pending_valid, wr);
        next();
      end
      bus.mem_readdata  = m;
      bus.rf_read_data  = old;
      bus.mem_readvalid = 1'b1;
      #1;
      chk("rv_rdaddr", bus.rf_read_addr, d);
      chk("rv_no_we", bus.regfile_write_enable, 0);
      next();
      bus.mem_readvalid = 1'b0;
      bus.mem_readdata  = $urandom;
      bus.rf_read_data  = $urandom;
    end
    #1;
    chk("wr_we", bus.regfile_write_enable, wr);
    if (wr) begin
      chk("wr_addr", bus.regfile_write_addr, d);
      chk("wr_data", bus.regfile_write_data, exp);
    end
    chk("wr_pending", bus.pending_valid, wr);
    chk("wr_ready", bus.req_ready, 1);
    next();
    #1;
    chk("after_we", bus.regfile_write_enable, 0);
    chk("after_pending", bus.pending_valid, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    clk_enable = 1'b1;
    reset      = 1'b1;

    // Reset state.
    next();
    next();
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_we", bus.regfile_write_enable, 0);
    chk("rst_pending", bus.pending_valid, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.req_ready, 1);
    chk("post_rst_waddr", bus.regfile_write_addr, 0);
    chk("post_rst_rdaddr", bus.rf_read_addr, 0);

    // ALU request dest=5.
    run_txn(1'b0, 3'd0, 5'd5, 32'h12345678, 2'd0, 32'd0, 32'd0, 0);

    // LB / LBU off=2, readvalid 3 cycles after accept.
    run_txn(1'b1, 3'd1, 5'd8, 32'd0, 2'd2, 32'h00800000, 32'hDEADBEEF, 2);
    chk("lb_const", ref_load(3'd1, 2, 32'h00800000, 32'd0), 32'hFFFFFF80);
    run_txn(1'b1, 3'd2, 5'd8, 32'd0, 2'd2, 32'h00800000, 32'hDEADBEEF, 2);

    // LWL / LWR k=1.
    run_txn(1'b1, 3'd5, 5'd10, 32'd0, 2'd1, 32'hAABBCCDD, 32'h11223344, 1);
    run_txn(1'b1, 3'd6, 5'd11, 32'd0, 2'd1, 32'hAABBCCDD, 32'h11223344, 0);

    // Back-to-back ALU requests dest=3 then dest=4.
    bus.req_valid    = 1'b1;
    bus.req_is_load  = 1'b0;
    bus.req_dest     = 5'd3;
    bus.req_alu_data = 32'h33333333;
    next();
    bus.req_dest     = 5'd4;
    bus.req_alu_data = 32'h44444444;
    #1;
    chk("b2b_ready", bus.req_ready, 1);
    chk("b2b_we1", bus.regfile_write_enable, 1);
    chk("b2b_addr1", bus.regfile_write_addr, 3);
    chk("b2b_data1", bus.regfile_write_data, 32'h33333333);
    next();
    bus.req_valid = 1'b0;
    #1;
    chk("b2b_we2", bus.regfile_write_enable, 1);
    chk("b2b_addr2", bus.regfile_write_addr, 4);
    chk("b2b_data2", bus.regfile_write_data, 32'h44444444);
    next();
    #1;
    chk("b2b_done", bus.regfile_write_enable, 0);

    // Destination $0: no strobe, no pending.
    run_txn(1'b0, 3'd0, 5'd0, 32'hCAFEF00D, 2'd0, 32'd0, 32'd0, 0);

    // Stall during WAIT_MEM: readvalid while disabled is not taken.
    bus.req_valid     = 1'b1;
    bus.req_is_load   = 1'b1;
    bus.req_dest      = 5'd7;
    bus.req_load_type = 3'd0;
    next();
    bus.req_valid     = 1'b0;
    clk_enable        = 1'b0;
    bus.mem_readvalid = 1'b1;
    bus.mem_readdata  = 32'h0BADF00D;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("stall_we", bus.regfile_write_enable, 0);
      chk("stall_rdaddr", bus.rf_read_addr, 7);
      next();
    end
    clk_enable        = 1'b1;
    bus.mem_readvalid = 1'b0;
    #1;
    chk("stall_still_wait", bus.rf_read_addr, 7);
    next();
    bus.mem_readvalid = 1'b1;
    bus.mem_readdata  = 32'h5A5A1234;
    next();
    bus.mem_readvalid = 1'b0;
    #1;
    chk("stall_we_late", bus.regfile_write_enable, 1);
    chk("stall_data", bus.regfile_write_data, 32'h5A5A1234);
    // Stall in WRITE: strobe masked, then re-fires.
    bus.req_valid    = 1'b1;
    bus.req_is_load  = 1'b0;
    bus.req_dest     = 5'd6;
    bus.req_alu_data = 32'h66666666;
    next();
    bus.req_valid = 1'b0;
    clk_enable    = 1'b0;
    #1;
    chk("hold_we_masked", bus.regfile_write_enable, 0);
    chk("hold_pending", bus.pending_valid, 1);
    next();
    clk_enable = 1'b1;
    #1;
    chk("hold_refire", bus.regfile_write_enable, 1);
    chk("hold_addr", bus.regfile_write_addr, 6);
    next();
    #1;
    chk("hold_done", bus.regfile_write_enable, 0);

    // Reset during WAIT_MEM aborts the load.
    bus.req_valid    = 1'b1;
    bus.req_is_load  = 1'b1;
    bus.req_dest     = 5'd9;
    next();
    bus.req_valid = 1'b0;
    reset         = 1'b1;
    #1;
    chk("abort_rst_ready", bus.req_ready, 0);
    chk("abort_rst_pending", bus.pending_valid, 0);
    next();
    reset             = 1'b0;
    bus.mem_readvalid = 1'b1;
    bus.mem_readdata  = 32'h99999999;
    #1;
    chk("abort_ready", bus.req_ready, 1);
    chk("abort_rdaddr", bus.rf_read_addr, 0);
    chk("abort_pending", bus.pending_valid, 0);
    chk("abort_we0", bus.regfile_write_enable, 0);
    next();
    bus.mem_readvalid = 1'b0;
    #1;
    chk("abort_we1", bus.regfile_write_enable, 0);

    // Random transactions against the reference formulas.
    for (int t = 0; t < 60; t++) begin
      run_txn(1'($urandom), 3'($urandom), 5'($urandom), $urandom, 2'($urandom),
              $urandom, $urandom, int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
